fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS.
- Owns the program counter and drives the word-aligned address into the asynchronous-read instruction memory (64 words).
- Captures the returned instruction into the IF/ID pipeline register consumed by the decode stage.
- Applies redirects (branch, jump, jr), hazard-unit stalls/flushes, range/alignment fault flagging, and keeps fetch/flush counters.

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 11 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select encodings, the NOP word and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_JR     = 2'd3
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus: the fetch stage drives the address, the memory returns the word combinationally.
interface fetch_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
);
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic [INSTR_WIDTH-1:0]   imem_instr;

    modport master (output imem_addr, input  imem_instr);
    modport slave  (input  imem_addr, output imem_instr);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, and a flush leaves an all-zero bubble.
module if_id_reg #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_stall,
    input  logic [INSTR_WIDTH-1:0]   i_instr,
    input  logic [ADDRESS_WIDTH-1:0] i_pc_plus4,
    input  logic                     i_fault,
    output logic [INSTR_WIDTH-1:0]   o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_pc_plus4,
    output logic                     o_valid,
    output logic                     o_fault
);

    logic [INSTR_WIDTH-1:0]   r_instr;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4;
    logic                     r_valid;
    logic                     r_fault;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else if (!i_stall) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
            r_fault    <= i_fault;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;
    assign o_fault    = r_fault;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, fault flagging,
// IF/ID capture and saturating fetch/flush counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = ADDRESS_WIDTH'(RESET_PC_DEF),
    parameter int                     IMEM_DEPTH    = 64,
    parameter int                     CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic [1:0]               pc_src,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic [ADDRESS_WIDTH-1:0] jump_target,
    input  logic [ADDRESS_WIDTH-1:0] jr_target,
    fetch_stage_if.master            imem,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [INSTR_WIDTH-1:0]   instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d,
    output logic                     fault_d,
    output logic [CNT_WIDTH-1:0]     fetch_count,
    output logic [CNT_WIDTH-1:0]     flush_count
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_MAX = ADDRESS_WIDTH'(IMEM_DEPTH * 4 - 4);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic [ADDRESS_WIDTH-1:0] w_pc_next;
    logic                     w_fault_f;
    logic [INSTR_WIDTH-1:0]   w_instr_f;
    logic                     w_capture;
    logic [CNT_WIDTH-1:0]     r_fetch_cnt;
    logic [CNT_WIDTH-1:0]     r_flush_cnt;

    assign w_pc_plus4 = r_pc + ADDRESS_WIDTH'(4);
    assign w_fault_f  = (r_pc[1:0] != 2'b00) || (r_pc > PC_MAX);
    assign w_instr_f  = w_fault_f ? INSTR_WIDTH'(NOP_INSTR) : imem.imem_instr;

    // Redirects outrank stall_f so a taken branch resolved in decode is never dropped.
    always_comb begin
        w_pc_next = w_pc_plus4;
        case (pc_src)
            PC_SRC_BRANCH: w_pc_next = branch_target;
            PC_SRC_JUMP:   w_pc_next = jump_target;
            PC_SRC_JR:     w_pc_next = jr_target;
            default:       if (stall_f) w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_pc <= RESET_PC;
        else        r_pc <= w_pc_next;
    end

    if_id_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .INSTR_WIDTH   (INSTR_WIDTH)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush_d),
        .i_stall    (stall_d),
        .i_instr    (w_instr_f),
        .i_pc_plus4 (w_pc_plus4),
        .i_fault    (w_fault_f),
        .o_instr    (instr_d),
        .o_pc_plus4 (pc_plus4_d),
        .o_valid    (valid_d),
        .o_fault    (fault_d)
    );

    assign w_capture = !flush_d && !stall_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_capture && (r_fetch_cnt != '1))
                r_fetch_cnt <= r_fetch_cnt + CNT_WIDTH'(1);
            if (flush_d && valid_d && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign imem.imem_addr = r_pc;
    assign pc_f           = r_pc;
    assign fetch_count    = r_fetch_cnt;
    assign flush_count    = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step pushes its hand-computed post-edge state,
// a negedge monitor pops and compares. Counters are narrowed to 4 bits to reach saturation.
module tb_fetch_stage;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int CW = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        v;
        logic        f;
        int          fc;
        int          flc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          stall_f, stall_d, flush_d;
    logic [1:0]    pc_src;
    logic [AW-1:0] branch_target, jump_target, jr_target;
    logic [AW-1:0] pc_f, pc_plus4_d;
    logic [IW-1:0] instr_d;
    logic          valid_d, fault_d;
    logic [CW-1:0] fetch_count, flush_count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    exp_t exp_q[$];

    fetch_stage_if #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    fetch_stage #(
        .ADDRESS_WIDTH (AW),
        .INSTR_WIDTH   (IW),
        .RESET_PC      (32'h0000_0000),
        .IMEM_DEPTH    (64),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem          (bus.master),
        .pc_f          (pc_f),
        .instr_d       (instr_d),
        .pc_plus4_d    (pc_plus4_d),
        .valid_d       (valid_d),
        .fault_d       (fault_d),
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words 0..3 are the small program; the rest are tagged with their word index.
    function automatic logic [31:0] memword(input int i);
        case (i)
            0:       return 32'h2008_0005;
            1:       return 32'h2009_0001;
            2:       return 32'h0109_5020;
            3:       return 32'h0000_0000;
            default: return 32'hA000_0000 + 32'(i);
        endcase
    endfunction

    // Out-of-range reads return junk so a missing NOP substitution shows up.
    always_comb begin
        bus.imem_instr = 32'hDEAD_BEEF;
        if (bus.imem_addr < 32'd256) bus.imem_instr = memword(int'(bus.imem_addr[7:2]));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_popped++;
            chk("pc_f",        pc_f,                e.pc);
            chk("imem_addr",   bus.imem_addr,       e.pc);
            chk("instr_d",     instr_d,             e.instr);
            chk("pc_plus4_d",  pc_plus4_d,          e.p4);
            chk("valid_d",     32'(valid_d),        32'(e.v));
            chk("fault_d",     32'(fault_d),        32'(e.f));
            chk("fetch_count", 32'(fetch_count),    32'(e.fc));
            chk("flush_count", 32'(flush_count),    32'(e.flc));
        end
    end

    // Drive one cycle; unselected target ports carry distinct decoys to catch a wrong mux leg.
    task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic [1:0] src, input logic [31:0] tgt,
                        input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_p4,
                        input logic e_v, input logic e_f, input int e_fc, input int e_flc);
        exp_t e;
        rst_n         = r;
        stall_f       = sf;
        stall_d       = sd;
        flush_d       = fd;
        pc_src        = src;
        branch_target = (src == 2'd1) ? tgt : 32'h0000_0080;
        jump_target   = (src == 2'd2) ? tgt : 32'h0000_0084;
        jr_target     = (src == 2'd3) ? tgt : 32'h0000_0088;
        @(posedge clk);
        #1;
        e.pc = e_pc; e.instr = e_instr; e.p4 = e_p4;
        e.v = e_v; e.f = e_f; e.fc = e_fc; e.flc = e_flc;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    initial begin
        // reset
        step(0,0,0,0,0,32'h0,   32'h0,  32'h0,        32'h0,  0,0, 0,0);
        step(0,0,0,0,0,32'h0,   32'h0,  32'h0,        32'h0,  0,0, 0,0);
        // free run
        step(1,0,0,0,0,32'h0,   32'h4,  32'h2008_0005, 32'h4, 1,0, 1,0);
        step(1,0,0,0,0,32'h0,   32'h8,  32'h2009_0001, 32'h8, 1,0, 2,0);
        // taken branch at pc 8 with flush -> bubble, then target word
        step(1,0,0,1,1,32'h20,  32'h20, 32'h0,        32'h0,  0,0, 2,1);
        step(1,0,0,0,0,32'h0,   32'h24, 32'hA000_0008, 32'h24,1,0, 3,1);
        // jump to 0x10 without flush, then full stall for 3 cycles
        step(1,0,0,0,2,32'h10,  32'h10, 32'hA000_0009, 32'h28,1,0, 4,1);
        for (int k = 0; k < 3; k++)
            step(1,1,1,0,0,32'h0, 32'h10, 32'hA000_0009, 32'h28,1,0, 4,1);
        step(1,0,0,0,0,32'h0,   32'h14, 32'hA000_0004, 32'h14,1,0, 5,1);
        // stall_f alone: same PC re-fetched and counted again
        step(1,1,0,0,0,32'h0,   32'h14, 32'hA000_0005, 32'h18,1,0, 6,1);
        // jr beats stall_f; flush beats stall_d
        step(1,1,1,1,3,32'h4,   32'h4,  32'h0,        32'h0,  0,0, 6,2);
        step(1,0,0,0,0,32'h0,   32'h8,  32'h2009_0001, 32'h8, 1,0, 7,2);
        // fault cases: misaligned, out of range, misaligned in range, last legal word
        step(1,0,0,1,1,32'h102, 32'h102,32'h0,        32'h0,  0,0, 7,3);
        step(1,0,0,0,2,32'h100, 32'h100,32'h0,        32'h106,1,1, 8,3);
        step(1,0,0,0,3,32'h6,   32'h6,  32'h0,        32'h104,1,1, 9,3);
        step(1,0,0,0,1,32'hFC,  32'hFC, 32'h0,        32'hA,  1,1, 10,3);
        step(1,0,0,0,0,32'h0,   32'h100,32'hA000_003F, 32'h100,1,0, 11,3);
        // PC+4 wraps from 0xFFFF_FFFC to 0
        step(1,0,0,0,3,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h104, 1,1, 12,3);
        step(1,0,0,0,0,32'h0,   32'h0,  32'h0,        32'h0,  1,1, 13,3);
        // flush of a bubble does not count
        step(1,0,0,1,0,32'h0,   32'h4,  32'h0,        32'h0,  0,0, 13,4);
        step(1,0,0,1,0,32'h0,   32'h8,  32'h0,        32'h0,  0,0, 13,4);
        // fetch_count reaches and holds all-ones
        step(1,0,0,0,2,32'h18,  32'h18, 32'h0109_5020, 32'hC, 1,0, 14,4);
        step(1,0,0,0,0,32'h0,   32'h1C, 32'hA000_0006, 32'h1C,1,0, 15,4);
        step(1,0,0,0,0,32'h0,   32'h20, 32'hA000_0007, 32'h20,1,0, 15,4);
        // mid-stream reset overrides a jump
        step(0,0,0,0,2,32'h40,  32'h0,  32'h0,        32'h0,  0,0, 0,0);
        step(1,0,0,0,0,32'h0,   32'h4,  32'h2008_0005, 32'h4, 1,0, 1,0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (n_popped != n_pushed || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: popped %0d expected %0d", n_popped, n_pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
